// File: rtl/ps2_digit_cursor_ctrl.sv
// ps2_digit_cursor_ctrl: PS/2 set-2 decoder driving a digit/cursor shadow that commits on vsync falling edge
module ps2_digit_cursor_ctrl #(
  parameter int STEP    = 40,
  parameter int X_MAX   = 600,
  parameter int Y_MAX   = 440,
  parameter int TIMEOUT = 1000000
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_N,
  input  logic [7:0] iscan,
  input  logic       iscan_valid,
  input  logic       iVGA_VS,
  output logic [7:0] oascii,
  output logic [9:0] ocur_x,
  output logic [9:0] ocur_y,
  output logic       opending
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  state_t state, state_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic vs_s, vs_h, commit, norm, ext, tmo;
  logic [7:0] sh_ascii, sh_ascii_n, ascii_n;
  logic [9:0] sh_x, sh_x_n, sh_y, sh_y_n, x_n, y_n;
  logic [10:0] x_up, y_up;
  assign commit = vs_h & ~vs_s;
  assign tmo    = tcnt == TW'(TIMEOUT - 1);
  assign x_up   = {1'b0, sh_x} + 11'(STEP);
  assign y_up   = {1'b0, sh_y} + 11'(STEP);
  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    norm    = 1'b0;
    ext     = 1'b0;
    if (iscan_valid) begin
      tcnt_n = '0;
      case (state)
        IDLE: begin
          state_n = iscan == 8'hE0 ? EXT : iscan == 8'hF0 ? BRK : IDLE;
          norm    = iscan != 8'hE0 && iscan != 8'hF0;
        end
        EXT: begin
          state_n = iscan == 8'hF0 ? EXT_BRK : IDLE;
          ext     = iscan != 8'hF0;
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE) begin
      tcnt_n  = tmo ? '0 : tcnt + 1'b1;
      state_n = tmo ? IDLE : state;
    end
  end
  always_comb begin
    sh_ascii_n = sh_ascii;
    sh_x_n     = sh_x;
    sh_y_n     = sh_y;
    if (norm)
      case (iscan)
        8'h45: sh_ascii_n = 8'h30;
        8'h16: sh_ascii_n = 8'h31;
        8'h1E: sh_ascii_n = 8'h32;
        8'h26: sh_ascii_n = 8'h33;
        8'h25: sh_ascii_n = 8'h34;
        8'h2E: sh_ascii_n = 8'h35;
        8'h36: sh_ascii_n = 8'h36;
        8'h3D: sh_ascii_n = 8'h37;
        8'h3E: sh_ascii_n = 8'h38;
        8'h46: sh_ascii_n = 8'h39;
        8'h76: begin
          sh_x_n = '0;
          sh_y_n = '0;
        end
        default: ;
      endcase
    if (ext)
      case (iscan)
        8'h6B: sh_x_n = {1'b0, sh_x} < 11'(STEP) ? '0 : sh_x - 10'(STEP);
        8'h74: sh_x_n = x_up > 11'(X_MAX) ? 10'(X_MAX) : x_up[9:0];
        8'h75: sh_y_n = {1'b0, sh_y} < 11'(STEP) ? '0 : sh_y - 10'(STEP);
        8'h72: sh_y_n = y_up > 11'(Y_MAX) ? 10'(Y_MAX) : y_up[9:0];
        default: ;
      endcase
  end
  // commit copies the pre-event shadow, so a same-cycle event waits a frame
  assign ascii_n = commit ? sh_ascii : oascii;
  assign x_n     = commit ? sh_x : ocur_x;
  assign y_n     = commit ? sh_y : ocur_y;
  always_ff @(posedge iVGA_CLK or negedge iRST_N)
    if (!iRST_N) begin
      state    <= IDLE;
      tcnt     <= '0;
      vs_s     <= 1'b1;
      vs_h     <= 1'b1;
      sh_ascii <= 8'h30;
      sh_x     <= '0;
      sh_y     <= '0;
      oascii   <= 8'h30;
      ocur_x   <= '0;
      ocur_y   <= '0;
      opending <= 1'b0;
    end else begin
      state    <= state_n;
      tcnt     <= tcnt_n;
      vs_s     <= iVGA_VS;
      vs_h     <= vs_s;
      sh_ascii <= sh_ascii_n;
      sh_x     <= sh_x_n;
      sh_y     <= sh_y_n;
      oascii   <= ascii_n;
      ocur_x   <= x_n;
      ocur_y   <= y_n;
      opending <= {sh_ascii_n, sh_x_n, sh_y_n} != {ascii_n, x_n, y_n};
    end
endmodule

// File: doc/ps2_digit_cursor_ctrl.md
Name: ps2_digit_cursor_ctrl

Overview:
Upstream feeder for the VGA digit-pattern stage. It consumes PS/2 set-2 scan-code bytes, tracks E0/F0 prefixes, maps digit make-codes to ASCII 0x30-0x39 and moves a 40-px character cursor with the arrow keys. Updates are staged in shadow registers and committed only at the vsync falling edge, so the pattern stage never redraws mid-frame.

Parameters:
STEP, 40, cursor step in pixels (x and y)
X_MAX, 600, largest legal ocur_x (640 - STEP)
Y_MAX, 440, largest legal ocur_y (480 - STEP)
TIMEOUT, 1000000, iVGA_CLK cycles a prefix state may wait for its next byte

Ports:
iVGA_CLK  input  1  pixel clock; all logic on its rising edge
iRST_N  input  1  asynchronous, active-low reset
iscan  input  8  scan-code byte, already synchronised to iVGA_CLK
iscan_valid  input  1  one-cycle strobe, iscan valid
iVGA_VS  input  1  vertical sync, active low, from the VGA controller
oascii  output  8  committed ASCII digit for the pattern stage
ocur_x  output  10  committed cursor x, pixel units
ocur_y  output  10  committed cursor y, pixel units
opending  output  1  shadow differs from committed outputs

Behaviour:
- Reset (async, iRST_N low): oascii=0x30, ocur_x=0, ocur_y=0, opending=0. Shadows take the same values. FSM goes to IDLE, timeout counter=0, vsync history register=1.
- Decoder FSM: acts only on cycles with iscan_valid=1.
  - IDLE: E0 goes to EXT. F0 goes to BRK. Any other byte is a normal make; stay in IDLE.
  - EXT: F0 goes to EXT_BRK. Any other byte is an extended make; go to IDLE.
  - BRK, EXT_BRK: any byte is discarded (key release); go to IDLE.
- Timeout: the counter clears on every valid byte and on entry to IDLE. In EXT, BRK or EXT_BRK it counts each cycle. When it reaches TIMEOUT-1 with no byte, the FSM returns to IDLE and no event is produced.
- Normal makes: 45,16,1E,26,25,2E,36,3D,3E,46 set shadow ascii to 30..39 in that order. 76 (Esc) sets shadow x=0, y=0. All other codes are ignored.
- Extended makes (all others ignored):
  - 6B left: x = (x < STEP) ? 0 : x - STEP
  - 74 right: x = (x + STEP > X_MAX) ? X_MAX : x + STEP
  - 75 up: y = (y < STEP) ? 0 : y - STEP
  - 72 down: y = (y + STEP > Y_MAX) ? Y_MAX : y + STEP
  - Compare in 11-bit width so there is no wrap. Saturate; never wrap around the screen.
- Typematic repeats (repeated makes with no break) are each treated as a new keypress.
- Commit: iVGA_VS is registered once. A falling edge (previous=1, current=0) copies the shadow values into oascii, ocur_x and ocur_y on the next edge, giving 2 cycles from VS low to outputs. Outputs are constant at all other times.
- Simultaneous event and commit in the same cycle: the commit copies the pre-event shadow. The event updates the shadow and is committed at the next frame.
- opending is registered: 1 whenever shadow and outputs differ, cleared by the commit cycle.
- Reset mid-sequence (e.g. after E0): the FSM returns to IDLE and the partial sequence is lost.

Test Plan:
- Reset, then bytes 16, then F0 16, then one VS falling edge -> oascii stays 0x30 until the VS edge, then 0x31; the break does not change it; opending goes 1 then 0.
- E0 74 sent 16 times, then a VS edge -> ocur_x=600 (saturated after 15 steps), ocur_y=0; then E0 6B -> 560 at the next frame.
- E0 75 at y=0, then E0 72 twice -> y stays 0, then reaches 80 after commit; E0 F0 72 (release) -> y unchanged.
- E0, then no byte for TIMEOUT cycles, then 72 -> treated as a normal make (ignored); cursor unchanged, FSM in IDLE.
- iscan_valid with 46 in the same cycle as the VS falling edge -> oascii keeps its old value this frame and shows 0x39 after the following VS edge.
- Assert iRST_N low while the FSM is in EXT_BRK with ocur_x=200 -> all outputs return to 0x30/0/0 immediately; next byte 74 is ignored as a normal make.
